// File: rtl/i2c_register_target_pkg.sv
// Shared constants for the I2C register target: FSM encodings, ACK levels and
// synchronizer depth.
package i2c_register_target_pkg;
  localparam int SYNC_DEPTH = 2;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ADDR     = 4'd1;
  localparam logic [3:0] S_ADDR_ACK = 4'd2;
  localparam logic [3:0] S_PTR      = 4'd3;
  localparam logic [3:0] S_WDATA    = 4'd4;
  localparam logic [3:0] S_WACK     = 4'd5;
  localparam logic [3:0] S_RDATA    = 4'd6;
  localparam logic [3:0] S_RACK     = 4'd7;
  localparam logic [3:0] S_IGNORE   = 4'd8;
endpackage

// File: rtl/i2c_line_sync.sv
// Metastability synchronizer for one I2C line plus an edge-detect flop.
module i2c_line_sync
  import i2c_register_target_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_DEPTH-1:0] sync;
  logic                  prev;

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[SYNC_DEPTH-2:0], din};
      prev <= sync[SYNC_DEPTH-1];
    end
  end

  assign level = sync[SYNC_DEPTH-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;
endmodule

// File: rtl/i2c_register_target.sv
// I2C target exposing a byte register file to the bus, with a parallel fabric
// port into the same registers.
module i2c_register_target
  import i2c_register_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         NREGS    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  inout  logic                     scl,
  inout  logic                     sda,
  input  logic [$clog2(NREGS)-1:0] reg_addr,
  input  logic [7:0]               reg_din,
  input  logic                     reg_we,
  output logic [7:0]               reg_dout,
  output logic                     wr_strobe,
  output logic [$clog2(NREGS)-1:0] wr_index,
  output logic                     busy
);
  localparam int AW = $clog2(NREGS);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;

  i2c_line_sync u_scl_sync (
    .clk(clk), .reset(reset), .din(scl),
    .level(scl_level), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk(clk), .reset(reset), .din(sda),
    .level(sda_level), .rise(sda_rise), .fall(sda_fall)
  );

  logic [3:0]    state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [AW-1:0] ptr;
  logic          rw;
  logic          rd_load;
  logic          sda_oe;
  logic [7:0]    regs [NREGS];

  logic       start, stop, addr_hit, commit;
  logic [7:0] rx_byte;

  assign start    = sda_fall & scl_level;
  assign stop     = sda_rise & scl_level;
  assign rx_byte  = {shreg[6:0], sda_level};
  assign addr_hit = (rx_byte[7:1] == DEV_ADDR) && (DEV_ADDR != 7'd0);
  assign commit   = (state == S_WDATA) && scl_rise && (bit_cnt == 4'd7) && !start && !stop;

  assign sda      = sda_oe ? 1'b0 : 1'bz;
  assign reg_dout = regs[reg_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= 4'd0;
      shreg   <= 8'd0;
      ptr     <= '0;
      rw      <= 1'b0;
      rd_load <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      if (stop)                    busy <= 1'b0;
      else if (state == S_ADDR_ACK) busy <= 1'b1;

      if (start) begin
        state   <= S_ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        rd_load <= 1'b0;
      end else if (stop) begin
        state   <= S_IDLE;
        sda_oe  <= 1'b0;
        rd_load <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_PTR, S_WDATA: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                if (state == S_ADDR) begin
                  if (addr_hit) begin
                    state <= S_ADDR_ACK;
                    rw    <= rx_byte[0];
                  end else begin
                    state <= S_IGNORE;
                  end
                end else if (state == S_PTR) begin
                  ptr   <= rx_byte[AW-1:0];
                  state <= S_WACK;
                end else begin
                  ptr   <= ptr + 1'b1;
                  state <= S_WACK;
                end
              end
            end
          end
          // First falling edge starts the ACK drive, the second ends it.
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else if (rw) begin
                state  <= S_RDATA;
                sda_oe <= ~regs[ptr][7];
                shreg  <= {regs[ptr][6:0], 1'b0};
              end else begin
                state  <= S_PTR;
                sda_oe <= 1'b0;
              end
            end
          end
          S_WACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                state  <= S_WDATA;
              end
            end
          end
          S_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (rd_load) begin
                rd_load <= 1'b0;
                sda_oe  <= ~regs[ptr][7];
                shreg   <= {regs[ptr][6:0], 1'b0};
              end else if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= S_RACK;
              end else begin
                sda_oe <= ~shreg[7];
                shreg  <= {shreg[6:0], 1'b0};
              end
            end
          end
          // The next byte loads on the falling edge that follows the master ACK.
          S_RACK: begin
            if (scl_rise) begin
              if (sda_level == ACK) begin
                ptr     <= ptr + 1'b1;
                rd_load <= 1'b1;
                bit_cnt <= 4'd0;
                state   <= S_RDATA;
              end else if (sda_level == NACK) begin
                state <= S_IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The I2C commit is applied after the fabric write so it wins a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'd0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
    end else begin
      wr_strobe <= commit;
      if (reg_we) regs[reg_addr] <= reg_din;
      if (commit) begin
        regs[ptr] <= rx_byte;
        wr_index  <= ptr;
      end
    end
  end
endmodule

// File: doc/i2c_register_target.md
# i2c_register_target

I2C target (slave) that answers the bus transactions issued by the wishbone-driven I2C master controller. It exposes a small byte-wide register file to the I2C bus and gives fabric logic a parallel read/write port into the same registers. It is used as an on-board loopback responder for bring-up and as the I2C-side register block for peripherals implemented in fabric.

## Interface
Parameters:
- `DEV_ADDR`, default 7'h42: 7-bit I2C device address the block answers to.
- `NREGS`, default 16: number of 8-bit registers. Must be a power of two, 2..256.

Ports:
- `clk` in 1: system clock. Must run at 20× the SCL rate or faster.
- `reset` in 1: synchronous, active-high. Returns the block to IDLE, clears all registers, and releases SDA.
- `scl` inout 1: I2C clock. The block only samples it and never drives it (no clock stretching).
- `sda` inout 1: I2C data, open-drain. Driven to 0 when `sda_oe` is high, otherwise high-Z.
- `reg_addr` in clog2(NREGS): fabric register index.
- `reg_din` in 8: fabric write data.
- `reg_we` in 1: fabric write enable, one cycle.
- `reg_dout` out 8: combinational read of `regs[reg_addr]`. Reset value 0.
- `wr_strobe` out 1: one-cycle pulse when an I2C write updates a register. Reset value 0.
- `wr_index` out clog2(NREGS): register index written, valid while `wr_strobe` is high. Reset value 0.
- `busy` out 1: high from an addressed START until STOP. Reset value 0.

## Operation
- SCL and SDA each pass through a 2-flop synchronizer, then a third flop used for edge detection.
- Bus events:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data bits are sampled on the detected SCL rising edge.
  - `sda_oe` changes only on the cycle after a detected SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, WDATA, WACK, RDATA, RACK, IGNORE.
- IDLE → ADDR on START.
- ADDR: shift in 8 bits, MSB first.
  - Bits [7:1] equal to DEV_ADDR → ADDR_ACK.
  - Otherwise → IGNORE (SDA stays released).
- ADDR_ACK: drive SDA low for one SCL period.
  - R/W = 0 → PTR.
  - R/W = 1 → load the shift register with `regs[ptr]` and go to RDATA.
- PTR: the first written byte sets `ptr` to `byte[clog2(NREGS)-1:0]`; upper bits are ignored. ACK, then → WDATA.
- WDATA: each byte is written to `regs[ptr]` with a `wr_strobe` pulse, then ACK, then `ptr` increments modulo NREGS. Sequence WDATA → WACK → WDATA.
- RDATA: shift out 8 bits, MSB first, driving SDA low for 0 bits. Then → RACK with SDA released.
- RACK, sampled at the SCL rising edge:
  - Master ACK (0): `ptr` increments modulo NREGS, the next byte is loaded, → RDATA.
  - Master NACK (1): → IGNORE.
- Boundary conditions:
  - START in any state, including a repeated START mid-transfer: → ADDR. The partial byte is discarded and `ptr` is kept.
  - STOP in any state: → IDLE with SDA released. A partial byte is discarded with no write.
  - Fabric write and I2C write to the same register in the same cycle: the I2C write wins.
  - Fabric writes to other registers always take effect.
  - Reset mid-transaction: the block is in IDLE and SDA is released on the next cycle. Following bus activity is ignored until a START.
  - General-call address (0x00) is not acknowledged.

## Timing
- An SCL/SDA pad change is seen internally 2 clk later; edges are flagged at 3 clk.
- ACK drive: `sda_oe` rises 1 clk after the detected falling SCL edge that ends bit 8, and falls 1 clk after the next detected falling SCL edge.
- Write commit: `regs[ptr]` update and `wr_strobe` occur 1 clk after the detected rising SCL edge of bit 8 of a data byte.
- `reg_dout` reflects an I2C or fabric write on the cycle after the write.
- `busy` rises 1 clk after ADDR_ACK is entered and falls 1 clk after STOP is detected.

## Structure
- Shared constants include file holds: the FSM state encodings, `ACK`=0 / `NACK`=1, and the synchronizer depth (2).
- Sub-module `i2c_line_sync`, instantiated once per line: 2-flop synchronizer plus edge flop, with outputs `level`, `rise`, `fall`.
- START/STOP detection and the FSM live in the top module.

## Test plan
- Write: START, 0x84, 0x03, 0xA5, 0x5A, STOP.
  - Expect ACK on all 4 bytes.
  - Expect `regs[3]`=0xA5 and `regs[4]`=0x5A.
  - Expect `wr_strobe` twice, with `wr_index` 3 then 4.
- Read with repeated START: START, 0x84, 0x03, Sr, 0x85, read two bytes (ACK, then NACK), STOP.
  - Expect bytes 0xA5 then 0x5A.
  - Expect `busy` low after STOP.
- Wrong address: START, 0x86, STOP.
  - Expect SDA never driven, `busy` never high, no register change.
- Pointer wrap: write pointer 0x0F, then 0x11, 0x22.
  - Expect `regs[15]`=0x11 and `regs[0]`=0x22.
- Collision: fabric `reg_we` with `reg_addr`=2 and 0x77 in the same cycle as the I2C commit of 0x99 to reg 2.
  - Expect `reg_dout` for reg 2 = 0x99.
- Abort cases:
  - STOP after 4 bits of a data byte: no write, block returns to IDLE.
  - `reset` asserted mid-read: `sda_oe` is 0 the next cycle, all registers read 0, and a new write transaction succeeds.
